pipelined_kd_traverser: RTL and testbench

PIPELINED_KD_TRAVERSER -- requirements
Module: pipelined_kd_traverser

---
 rtl/kd_pkg.sv | 22 ++
 rtl/kd_level_stage.sv | 102 ++++++++++
 rtl/pipelined_kd_traverser.sv | 114 +++++++++++
 tb/tb_pipelined_kd_traverser.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kd_pkg.sv
// Shared defaults and node-word field helpers for the k-d tree traverser.
package kd_pkg;

   localparam int unsigned KD_DATA_WIDTH = 11;
   localparam int unsigned KD_NUM_DIMS   = 5;
   localparam int unsigned KD_LEVELS     = 6;
   localparam int unsigned KD_DIM_WIDTH  = 3;
   localparam int unsigned KD_TAG_WIDTH  = 8;

   // Node word layout is {median, dim}; dim sits in the low dim_w bits.
   function automatic logic [31:0] node_dim(input logic [63:0] node,
                                            input int unsigned dim_w);
      return 32'(node & ((64'd1 << dim_w) - 64'd1));
   endfunction

   function automatic logic [31:0] node_median(input logic [63:0] node,
                                               input int unsigned dim_w,
                                               input int unsigned data_w);
      return 32'((node >> dim_w) & ((64'd1 << data_w) - 64'd1));
   endfunction

endpackage

// File: rtl/kd_level_stage.sv
// One tree level: private node bank, pipeline register and split compare.
// The register sits at the stage input; the bank is read with the registered
// path so a same-cycle write is only seen by the next query.
module kd_level_stage
   import kd_pkg::*;
#(
   parameter int unsigned LEVEL      = 0,
   parameter int unsigned DATA_WIDTH = KD_DATA_WIDTH,
   parameter int unsigned NUM_DIMS   = KD_NUM_DIMS,
   parameter int unsigned LEVELS     = KD_LEVELS,
   parameter int unsigned DIM_WIDTH  = KD_DIM_WIDTH,
   parameter int unsigned TAG_WIDTH  = KD_TAG_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             stall_i,
   input  logic                             in_valid_i,
   input  logic [NUM_DIMS*DATA_WIDTH-1:0]   in_patch_i,
   input  logic [TAG_WIDTH-1:0]             in_tag_i,
   input  logic [LEVELS-1:0]                in_path_i,
   input  logic                             wen_i,
   input  logic [LEVELS-1:0]                waddr_i,
   input  logic [DATA_WIDTH+DIM_WIDTH-1:0]  wdata_i,
   output logic                             out_valid_o,
   output logic [NUM_DIMS*DATA_WIDTH-1:0]   out_patch_o,
   output logic [TAG_WIDTH-1:0]             out_tag_o,
   output logic [LEVELS-1:0]                out_path_o,
   output logic                             bad_o
);

   localparam int unsigned NW    = DATA_WIDTH + DIM_WIDTH;
   localparam int unsigned DEPTH = 1 << LEVEL;
   localparam int unsigned IDXW  = (LEVEL > 0) ? LEVEL : 1;
   localparam int unsigned BASE  = DEPTH - 1;

   logic [NW-1:0]                   bank_q [DEPTH];
   logic                            valid_q;
   logic [NUM_DIMS*DATA_WIDTH-1:0]  patch_q;
   logic [TAG_WIDTH-1:0]            tag_q;
   logic [LEVELS-1:0]               path_q;

   logic                            bank_hit;
   logic [IDXW-1:0]                 wr_idx;
   logic [IDXW-1:0]                 rd_idx;
   logic [NW-1:0]                   node;
   logic [DIM_WIDTH-1:0]            dim;
   logic [DATA_WIDTH-1:0]           median;
   logic [DATA_WIDTH-1:0]           comp;
   logic                            dim_bad;
   logic                            go_right;

   // Decode whether the global heap address lands in this level's bank.
   always_comb begin
      bank_hit = wen_i && (32'(waddr_i) >= BASE) && (32'(waddr_i) < BASE + DEPTH);
      wr_idx   = IDXW'(32'(waddr_i) - BASE);
      rd_idx   = (LEVEL > 0) ? IDXW'(path_q) : '0;
   end

   // Node bank write; contents intentionally not reset.
   always_ff @(posedge clk) begin
      if (bank_hit) begin
         bank_q[wr_idx] <= wdata_i;
      end
   end

   // Stage pipeline register, frozen while the result port is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         patch_q <= '0;
         tag_q   <= '0;
         path_q  <= '0;
      end else if (!stall_i) begin
         valid_q <= in_valid_i;
         patch_q <= in_patch_i;
         tag_q   <= in_tag_i;
         path_q  <= in_path_i;
      end
   end

   // Read node, select split component (component 0 on bad dim), compare.
   always_comb begin
      node    = bank_q[rd_idx];
      dim     = DIM_WIDTH'(node_dim(64'(node), DIM_WIDTH));
      median  = DATA_WIDTH'(node_median(64'(node), DIM_WIDTH, DATA_WIDTH));
      dim_bad = (32'(dim) >= NUM_DIMS);
      comp    = patch_q[DATA_WIDTH-1:0];
      for (int unsigned d = 1; d < NUM_DIMS; d++) begin
         if (32'(dim) == d) begin
            comp = patch_q[d*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      go_right = !($signed(comp) < $signed(median));
   end

   assign out_valid_o = valid_q;
   assign out_patch_o = patch_q;
   assign out_tag_o   = tag_q;
   assign out_path_o  = LEVELS'({path_q, go_right});
   assign bad_o       = valid_q && dim_bad;

endmodule

// File: rtl/pipelined_kd_traverser.sv
// Fully pipelined k-d tree leaf lookup: one level per stage, one query/cycle.
module pipelined_kd_traverser
   import kd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = KD_DATA_WIDTH,
   parameter int unsigned NUM_DIMS   = KD_NUM_DIMS,
   parameter int unsigned LEVELS     = KD_LEVELS,
   parameter int unsigned DIM_WIDTH  = KD_DIM_WIDTH,
   parameter int unsigned TAG_WIDTH  = KD_TAG_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             load_mode,
   input  logic                             node_wen,
   input  logic [LEVELS-1:0]                node_waddr,
   input  logic [DATA_WIDTH+DIM_WIDTH-1:0]  node_wdata,
   input  logic                             patch_valid,
   output logic                             patch_ready,
   input  logic [NUM_DIMS*DATA_WIDTH-1:0]   patch_in,
   input  logic [TAG_WIDTH-1:0]             patch_tag,
   output logic                             leaf_valid,
   input  logic                             leaf_ready,
   output logic [LEVELS-1:0]                leaf_index,
   output logic [TAG_WIDTH-1:0]             leaf_tag,
   output logic                             dim_err
);

   localparam int unsigned NODE_COUNT = (1 << LEVELS) - 1;

   logic                            stall;
   logic                            accept;
   logic                            node_write;
   logic                            any_bad;

   logic                            chain_valid [LEVELS+1];
   logic [NUM_DIMS*DATA_WIDTH-1:0]  chain_patch [LEVELS+1];
   logic [TAG_WIDTH-1:0]            chain_tag   [LEVELS+1];
   logic [LEVELS-1:0]               chain_path  [LEVELS+1];
   logic                            stage_bad   [LEVELS];

   logic                            leaf_valid_q;
   logic [LEVELS-1:0]               leaf_index_q;
   logic [TAG_WIDTH-1:0]            leaf_tag_q;
   logic                            dim_err_q;

   // Handshake, write qualification and sticky-error source.
   always_comb begin
      stall       = leaf_valid_q && !leaf_ready;
      patch_ready = !load_mode && !stall;
      accept      = patch_valid && patch_ready;
      node_write  = node_wen && load_mode && (32'(node_waddr) < NODE_COUNT);
      any_bad     = 1'b0;
      for (int unsigned l = 0; l < LEVELS; l++) begin
         any_bad = any_bad | stage_bad[l];
      end
   end

   assign chain_valid[0] = accept;
   assign chain_patch[0] = patch_in;
   assign chain_tag[0]   = patch_tag;
   assign chain_path[0]  = '0;

   for (genvar g = 0; g < LEVELS; g++) begin : g_level
      kd_level_stage #(
         .LEVEL      (g),
         .DATA_WIDTH (DATA_WIDTH),
         .NUM_DIMS   (NUM_DIMS),
         .LEVELS     (LEVELS),
         .DIM_WIDTH  (DIM_WIDTH),
         .TAG_WIDTH  (TAG_WIDTH)
      ) u_stage (
         .clk         (clk),
         .rst         (rst),
         .stall_i     (stall),
         .in_valid_i  (chain_valid[g]),
         .in_patch_i  (chain_patch[g]),
         .in_tag_i    (chain_tag[g]),
         .in_path_i   (chain_path[g]),
         .wen_i       (node_write),
         .waddr_i     (node_waddr),
         .wdata_i     (node_wdata),
         .out_valid_o (chain_valid[g+1]),
         .out_patch_o (chain_patch[g+1]),
         .out_tag_o   (chain_tag[g+1]),
         .out_path_o  (chain_path[g+1]),
         .bad_o       (stage_bad[g])
      );
   end

   // Result register (held under stall) and sticky dim error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         leaf_valid_q <= 1'b0;
         leaf_index_q <= '0;
         leaf_tag_q   <= '0;
         dim_err_q    <= 1'b0;
      end else begin
         if (!stall) begin
            leaf_valid_q <= chain_valid[LEVELS];
            if (chain_valid[LEVELS]) begin
               leaf_index_q <= chain_path[LEVELS];
               leaf_tag_q   <= chain_tag[LEVELS];
            end
         end
         dim_err_q <= dim_err_q | any_bad;
      end
   end

   assign leaf_valid = leaf_valid_q;
   assign leaf_index = leaf_index_q;
   assign leaf_tag   = leaf_tag_q;
   assign dim_err    = dim_err_q;

endmodule

// File: tb/tb_pipelined_kd_traverser.sv
// Randomized bench with a queue-based reference model of the k-d traversal.
module tb_pipelined_kd_traverser;

   localparam int DW   = 11;
   localparam int ND   = 5;
   localparam int L    = 6;
   localparam int DIMW = 3;
   localparam int TW   = 8;
   localparam int PW   = ND * DW;
   localparam int NN   = (1 << L) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              load_mode;
   logic              node_wen;
   logic [L-1:0]      node_waddr;
   logic [DW+DIMW-1:0] node_wdata;
   logic              patch_valid;
   logic              patch_ready;
   logic [PW-1:0]     patch_in;
   logic [TW-1:0]     patch_tag;
   logic              leaf_valid;
   logic              leaf_ready;
   logic [L-1:0]      leaf_index;
   logic [TW-1:0]     leaf_tag;
   logic              dim_err;

   always #5 clk = ~clk;

   pipelined_kd_traverser #(
      .DATA_WIDTH (DW),
      .NUM_DIMS   (ND),
      .LEVELS     (L),
      .DIM_WIDTH  (DIMW),
      .TAG_WIDTH  (TW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load_mode   (load_mode),
      .node_wen    (node_wen),
      .node_waddr  (node_waddr),
      .node_wdata  (node_wdata),
      .patch_valid (patch_valid),
      .patch_ready (patch_ready),
      .patch_in    (patch_in),
      .patch_tag   (patch_tag),
      .leaf_valid  (leaf_valid),
      .leaf_ready  (leaf_ready),
      .leaf_index  (leaf_index),
      .leaf_tag    (leaf_tag),
      .dim_err     (dim_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int medv [NN];
   int dimv [NN];
   int pc   [ND];

   function automatic int comp_of(input logic [PW-1:0] p, input int d);
      logic [DW-1:0] v;
      v = p[d*DW +: DW];
      return int'($signed(v));
   endfunction

   // Walk the tree from the root: go right when component >= median.
   function automatic void model_trav(input logic [PW-1:0] p, output int idx, output bit bad);
      int pos;
      pos = 0;
      bad = 1'b0;
      for (int l = 0; l < L; l++) begin
         int a;
         int c;
         a = (1 << l) - 1 + pos;
         if (dimv[a] >= ND) begin
            bad = 1'b1;
            c = comp_of(p, 0);
         end else begin
            c = comp_of(p, dimv[a]);
         end
         pos = 2 * pos + ((c >= medv[a]) ? 1 : 0);
      end
      idx = pos;
   endfunction

   function automatic logic [PW-1:0] pack_pc();
      logic [PW-1:0] v;
      v = '0;
      for (int d = 0; d < ND; d++) v[d*DW +: DW] = DW'(pc[d]);
      return v;
   endfunction

   typedef struct {
      int idx;
      int tag;
      bit bad;
      int acc_cyc;
      int acc_stall;
   } exp_t;

   exp_t q[$];
   int   cyc       = 0;
   int   stall_cnt = 0;
   int   n_deliv   = 0;
   int   n_acc     = 0;
   bit   bad_acc   = 0;
   bit   bad_del   = 0;
   bit   prev_hold = 0;

   // Single compare process: sampled on the falling edge, mid-cycle.
   always @(negedge clk) begin : mon
      exp_t e;
      int   midx;
      bit   mbad;
      bit   stl;
      cyc++;
      if (rst) begin
         q.delete();
         bad_acc   = 0;
         bad_del   = 0;
         prev_hold = 0;
      end else begin
         stl = leaf_valid && !leaf_ready;
         chk("patch_ready", patch_ready, !load_mode && !stl);
         if (leaf_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_leaf_valid", leaf_valid, 0);
            end else begin
               e = q[0];
               chk("leaf_index", leaf_index, e.idx);
               chk("leaf_tag", leaf_tag, e.tag);
               if (!prev_hold)
                  chk("latency", cyc - e.acc_cyc, 1 + L + (stall_cnt - e.acc_stall));
               if (leaf_ready) begin
                  if (e.bad) bad_del = 1;
                  void'(q.pop_front());
                  n_deliv++;
               end
            end
         end
         if (bad_del) chk("dim_err_set", dim_err, 1);
         if (!bad_acc) chk("dim_err_clear", dim_err, 0);
         if (patch_valid && patch_ready) begin
            model_trav(patch_in, midx, mbad);
            e.idx       = midx;
            e.tag       = int'(patch_tag);
            e.bad       = mbad;
            e.acc_cyc   = cyc;
            e.acc_stall = stall_cnt;
            q.push_back(e);
            n_acc++;
            if (mbad) bad_acc = 1;
         end
         prev_hold = stl;
         if (stl) stall_cnt++;
      end
   end

   // ---------------- stimulus helpers (slot = posedge + 2) ----------------
   task automatic next_slot();
      @(posedge clk);
      #2;
   endtask

   task automatic wr_node(input int a, input int m, input int d);
      logic [DW-1:0]   mv;
      logic [DIMW-1:0] dv;
      mv = DW'(m);
      dv = DIMW'(d);
      load_mode  = 1'b1;
      node_wen   = 1'b1;
      node_waddr = L'(a);
      node_wdata = {mv, dv};
      next_slot();
      node_wen = 1'b0;
      if (a < NN) begin
         medv[a] = m;
         dimv[a] = d;
      end
   endtask

   task automatic load_tree(input int kind, input int maxdim);
      for (int a = 0; a < NN; a++) begin
         if (kind == 0) wr_node(a, 0, 0);
         else wr_node(a, (int'($urandom_range(0, 8)) - 4) * 25, int'($urandom_range(0, maxdim)));
      end
      load_mode = 1'b0;
   endtask

   task automatic rand_patch();
      for (int d = 0; d < ND; d++) begin
         if ($urandom % 4 == 0) pc[d] = int'($urandom_range(0, 2047)) - 1024;
         else pc[d] = (int'($urandom_range(0, 8)) - 4) * 25;
      end
      patch_in = pack_pc();
   endtask

   task automatic issue(input int tag);
      bit acc;
      int tries;
      rand_patch();
      patch_tag   = TW'(tag);
      patch_valid = 1'b1;
      acc   = 0;
      tries = 0;
      while (!acc && tries < 50) begin
         @(negedge clk);
         acc = patch_ready;
         next_slot();
         tries++;
      end
      if (!acc) chk("issue_timeout", 0, 1);
      patch_valid = 1'b0;
   endtask

   task automatic rand_phase(input int n);
      for (int i = 0; i < n; i++) begin
         patch_valid = ($urandom % 4) != 0;
         rand_patch();
         patch_tag  = TW'($urandom);
         leaf_ready = ($urandom % 3) != 0;
         next_slot();
      end
      patch_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      patch_valid = 1'b0;
      leaf_ready  = 1'b1;
      t = 0;
      while (q.size() != 0 && t < 200) begin
         next_slot();
         t++;
      end
      next_slot();
      chk("drain_empty", q.size(), 0);
   endtask

   // One query with hand-computed leaf; also checks the edge-count latency.
   task automatic lit_query(input string nm, input int d0, input int d2, input int tag, input int exp_idx);
      int n;
      bit got;
      for (int d = 0; d < ND; d++) pc[d] = 0;
      pc[0] = d0;
      pc[2] = d2;
      patch_in    = pack_pc();
      patch_tag   = TW'(tag);
      patch_valid = 1'b1;
      leaf_ready  = 1'b1;
      @(negedge clk);
      chk({nm, "_ready"}, patch_ready, 1);
      next_slot();
      patch_valid = 1'b0;
      n   = 0;
      got = 0;
      while (!got && n < 20) begin
         @(posedge clk);
         #1;
         n++;
         got = leaf_valid;
      end
      chk({nm, "_latency"}, n, L);
      chk({nm, "_index"}, leaf_index, exp_idx);
      chk({nm, "_tag"}, leaf_tag, tag);
      #1;
   endtask

   // ---------------- main sequence ----------------
   initial begin : stim
      int midx;
      bit mbad;
      int d0;
      int a0;
      rst = 1'b1; load_mode = 1'b0; node_wen = 1'b0; node_waddr = '0; node_wdata = '0;
      patch_valid = 1'b0; patch_in = '0; patch_tag = '0; leaf_ready = 1'b1;
      for (int a = 0; a < NN; a++) begin medv[a] = 0; dimv[a] = 0; end
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_leaf_valid", leaf_valid, 0);
      chk("rst_leaf_index", leaf_index, 0);
      chk("rst_leaf_tag", leaf_tag, 0);
      chk("rst_dim_err", dim_err, 0);
      chk("rst_patch_ready", patch_ready, 1);
      next_slot();

      // All-zero tree: sign of component 0 decides everything.
      load_tree(0, 0);
      for (int d = 0; d < ND; d++) pc[d] = 0;
      pc[0] = -1;
      model_trav(pack_pc(), midx, mbad);
      chk("model_zero_neg", midx, 0);
      pc[0] = 0;
      model_trav(pack_pc(), midx, mbad);
      chk("model_zero_eq", midx, 63);
      lit_query("zero_neg", -1, 0, 'h11, 0);
      lit_query("zero_eq", 0, 0, 'h22, 63);

      // Root splits on component 2 at 100; equal goes right.
      wr_node(0, 100, 2);
      load_mode = 1'b0;
      for (int d = 0; d < ND; d++) pc[d] = 0;
      pc[0] = -5; pc[2] = 150;
      model_trav(pack_pc(), midx, mbad);
      chk("model_root_d2", midx, 32);
      lit_query("root_gt", -5, 150, 'h31, 32);
      lit_query("root_eq", -5, 100, 'h32, 32);
      lit_query("root_lt", -5, 99, 'h33, 0);

      // Random tree, random traffic and backpressure.
      load_tree(1, ND - 1);
      rand_phase(400);
      drain();

      // 8 back-to-back queries with a 3-cycle result stall mid-stream.
      d0 = n_deliv;
      fork
         begin
            for (int i = 0; i < 8; i++) issue(i);
         end
         begin
            repeat (8) @(posedge clk);
            #2 leaf_ready = 1'b0;
            repeat (3) @(posedge clk);
            #2 leaf_ready = 1'b1;
         end
      join
      drain();
      chk("b2b_delivered", n_deliv - d0, 8);

      // load_mode with queries in flight: they complete, nothing new enters.
      d0 = n_deliv;
      issue(1); issue(2); issue(3);
      a0 = n_acc;
      load_mode   = 1'b1;
      patch_valid = 1'b1;
      rand_patch();
      repeat (4) next_slot();
      wr_node(63, 123, 1);
      repeat (8) next_slot();
      chk("loadmode_no_accept", n_acc - a0, 0);
      patch_valid = 1'b0;
      load_mode   = 1'b0;
      drain();
      chk("loadmode_inflight_done", n_deliv - d0, 3);
      rand_phase(100);
      drain();

      // Out-of-range dim at the root falls back to component 0.
      load_tree(0, 0);
      wr_node(0, 0, 7);
      load_mode = 1'b0;
      lit_query("baddim_neg", -1, 0, 'h41, 0);
      chk("baddim_err", dim_err, 1);
      lit_query("baddim_eq", 0, 0, 'h42, 63);
      drain();
      chk("baddim_sticky", dim_err, 1);

      // Reset with three queries in flight drops them all.
      d0 = n_deliv;
      issue(5); issue(6); issue(7);
      next_slot();
      rst = 1'b1;
      next_slot();
      next_slot();
      rst = 1'b0;
      @(negedge clk);
      chk("rstflight_leaf_valid", leaf_valid, 0);
      chk("rstflight_dim_err", dim_err, 0);
      next_slot();
      repeat (15) next_slot();
      chk("rstflight_no_late", n_deliv - d0, 0);

      // Random tree including illegal dims, random traffic.
      load_tree(1, 7);
      rand_phase(300);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end

endmodule
